cascade_slave_responder: RTL and testbench

//  Slave-side end of the PIC cascade bus. In slave mode (sp_neg=0, cascade), tracks the INTA pulse

---
 rtl/pic_pkg.sv | 23 ++
 rtl/inta_edge_sync.sv | 24 ++
 rtl/cascade_slave_responder.sv | 178 +++++++++++++++++
 tb/tb_cascade_slave_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade logic.
package pic_pkg;

  localparam int CAS_W_DEF        = 3;
  localparam int DATA_W_DEF       = 8;
  localparam int INTA_PULSES_8086 = 2;
  localparam int INTA_PULSES_8080 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SELECTED,
    ST_IGNORE,
    ST_DRIVE,
    ST_DONE
  } casc_state_t;

  // Number of the final INTA pulse for the latched processor mode.
  function automatic logic [1:0] last_pulse(input logic is_8086);
    return is_8086 ? 2'(INTA_PULSES_8086) : 2'(INTA_PULSES_8080);
  endfunction

endpackage

// File: rtl/inta_edge_sync.sv
// Two-flop synchroniser for the asynchronous INTA pin plus a third flop
// for fall/rise edge detection.
module inta_edge_sync (
  input  logic clk,
  input  logic rst_neg,
  input  logic inta_neg,
  output logic inta_sync,
  output logic fall_pulse,
  output logic rise_pulse
);

  logic [2:0] sync_q;

  // INTA idles high, so the chain resets high to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], inta_neg};
  end

  assign inta_sync  = sync_q[1];
  assign fall_pulse =  sync_q[2] & ~sync_q[1];
  assign rise_pulse = ~sync_q[2] &  sync_q[1];

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave-side cascade responder: follows the INTA sequence, matches the CAS
// slave ID, and drives vector / CALL address bytes onto the data bus.
module cascade_slave_responder
  import pic_pkg::*;
#(
  parameter int CAS_W  = CAS_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_neg,
  input  logic              sp_neg,
  input  logic              single_mode_flag,
  input  logic              mode_8086_flag,
  input  logic              aeoi_flag,
  input  logic              inta_neg,
  input  logic [CAS_W-1:0]  cascading_lines,
  input  logic [CAS_W-1:0]  my_slave_id,
  input  logic              int_pending,
  input  logic [DATA_W-1:0] vector_8086,
  input  logic [15:0]       call_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              isr_set_pulse,
  output logic              aeoi_pulse,
  output logic              seq_active
);

  casc_state_t       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, cnt_inc;
  logic              mode_q, mode_d;
  logic              aeoi_lat_q, aeoi_lat_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] vec_q, vec_d;
  logic [15:0]       call_q, call_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              isr_q, isr_d;
  logic              aeoi_q, aeoi_d;
  logic [CAS_W-1:0]  cas_s1_q, cas_s2_q;
  logic              inta_sync, inta_fall, inta_rise;
  logic              enabled;

  inta_edge_sync u_inta_sync (
    .clk        (clk),
    .rst_neg    (rst_neg),
    .inta_neg   (inta_neg),
    .inta_sync  (inta_sync),
    .fall_pulse (inta_fall),
    .rise_pulse (inta_rise)
  );

  assign enabled = ~sp_neg & ~single_mode_flag;
  assign cnt_inc = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;

  // NOTE: every variable gets its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    aeoi_lat_d = aeoi_lat_q;
    sel_d      = sel_q;
    vec_d      = vec_q;
    call_d     = call_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    isr_d      = 1'b0;
    aeoi_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d      = 2'd0;
        sel_d      = 1'b0;
        data_oe_d  = 1'b0;
        data_out_d = '0;
        if (inta_fall && enabled) begin
          state_d    = ST_FIRST;
          cnt_d      = 2'd1;
          mode_d     = mode_8086_flag;
          aeoi_lat_d = aeoi_flag;
        end
      end
      ST_FIRST: begin
        if (inta_rise) begin
          if (cas_s2_q == my_slave_id && int_pending) begin
            state_d = ST_SELECTED;
            sel_d   = 1'b1;
            isr_d   = 1'b1;
            vec_d   = vector_8086;
            call_d  = call_addr;
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end
      ST_SELECTED: begin
        if (inta_fall) begin
          state_d   = ST_DRIVE;
          cnt_d     = cnt_inc;
          data_oe_d = 1'b1;
          if (mode_q)               data_out_d = vec_q;
          else if (cnt_inc == 2'd2) data_out_d = DATA_W'(call_q[7:0]);
          else                      data_out_d = DATA_W'(call_q[15:8]);
        end
      end
      ST_DRIVE: begin
        if (inta_rise) begin
          data_oe_d  = 1'b0;
          data_out_d = '0;
          if (cnt_q == last_pulse(mode_q)) begin
            state_d = ST_DONE;
            aeoi_d  = sel_q & aeoi_lat_q;
          end else begin
            state_d = ST_SELECTED;
          end
        end
      end
      ST_IGNORE: begin
        if (inta_fall) cnt_d = cnt_inc;
        if (inta_rise && cnt_q == last_pulse(mode_q)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Mode pins leaving cascade-slave configuration abort any sequence.
    if (state_q != ST_IDLE && !enabled) begin
      state_d    = ST_IDLE;
      cnt_d      = 2'd0;
      sel_d      = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = '0;
      isr_d      = 1'b0;
      aeoi_d     = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      mode_q     <= 1'b0;
      aeoi_lat_q <= 1'b0;
      sel_q      <= 1'b0;
      vec_q      <= '0;
      call_q     <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      isr_q      <= 1'b0;
      aeoi_q     <= 1'b0;
      cas_s1_q   <= '0;
      cas_s2_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      aeoi_lat_q <= aeoi_lat_d;
      sel_q      <= sel_d;
      vec_q      <= vec_d;
      call_q     <= call_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      isr_q      <= isr_d;
      aeoi_q     <= aeoi_d;
      cas_s1_q   <= cascading_lines;
      cas_s2_q   <= cas_s1_q;
    end
  end

  assign data_out      = data_out_q;
  assign data_oe       = data_oe_q;
  assign isr_set_pulse = isr_q;
  assign aeoi_pulse    = aeoi_q;
  assign seq_active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Directed bench for cascade_slave_responder: INTA sequences with
// hand-computed expected bytes, pulse counts and phases.
module tb_cascade_slave_responder;

  logic       clk = 1'b0;
  logic       rst_neg;
  logic       sp_neg, single_mode_flag, mode_8086_flag, aeoi_flag;
  logic       inta_neg;
  logic [2:0] cascading_lines, my_slave_id;
  logic       int_pending;
  logic [7:0] vector_8086;
  logic [15:0] call_addr;
  logic [7:0] data_out;
  logic       data_oe, isr_set_pulse, aeoi_pulse, seq_active;

  int checks = 0;
  int errors = 0;

  // Monitor state: counts and first-cycle captures per scenario.
  int   phase = 0;
  int   isr_cnt, aeoi_cnt, oe_cycles, seq_cycles, isr_phase;
  logic oe_prev;
  logic [7:0] bytes[$];
  int   oe_phase[$];

  always #5 clk = ~clk;

  cascade_slave_responder dut (
    .clk              (clk),
    .rst_neg          (rst_neg),
    .sp_neg           (sp_neg),
    .single_mode_flag (single_mode_flag),
    .mode_8086_flag   (mode_8086_flag),
    .aeoi_flag        (aeoi_flag),
    .inta_neg         (inta_neg),
    .cascading_lines  (cascading_lines),
    .my_slave_id      (my_slave_id),
    .int_pending      (int_pending),
    .vector_8086      (vector_8086),
    .call_addr        (call_addr),
    .data_out         (data_out),
    .data_oe          (data_oe),
    .isr_set_pulse    (isr_set_pulse),
    .aeoi_pulse       (aeoi_pulse),
    .seq_active       (seq_active)
  );

  always @(negedge clk) begin
    if (isr_set_pulse) begin
      isr_cnt   <= isr_cnt + 1;
      isr_phase <= phase;
    end
    if (aeoi_pulse) aeoi_cnt   <= aeoi_cnt + 1;
    if (data_oe)    oe_cycles  <= oe_cycles + 1;
    if (seq_active) seq_cycles <= seq_cycles + 1;
    if (data_oe && !oe_prev) begin
      bytes.push_back(data_out);
      oe_phase.push_back(phase);
    end
    oe_prev <= data_oe;
  end

  task automatic clear_mon();
    @(posedge clk);
    isr_cnt = 0; aeoi_cnt = 0; oe_cycles = 0; seq_cycles = 0;
    isr_phase = 0; phase = 0;
    bytes.delete();
    oe_phase.delete();
  endtask

  // Pulse n: phase 2n-1 while INTA low, 2n while high.
  task automatic inta_pulse(input int n);
    @(posedge clk); #1;
    phase = 2*n - 1;
    inta_neg = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    phase = 2*n;
    inta_neg = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic apply_reset();
    rst_neg = 1'b0;
    sp_neg = 1'b0; single_mode_flag = 1'b0; mode_8086_flag = 1'b1;
    aeoi_flag = 1'b0; inta_neg = 1'b1; cascading_lines = 3'd0;
    my_slave_id = 3'd0; int_pending = 1'b0; vector_8086 = 8'h00;
    call_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #2 rst_neg = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got=%b exp=0", data_oe); end
    checks++; if (isr_set_pulse !== 1'b0) begin errors++; $display("FAIL reset_isr got=%b exp=0", isr_set_pulse); end
    checks++; if (aeoi_pulse !== 1'b0) begin errors++; $display("FAIL reset_aeoi got=%b exp=0", aeoi_pulse); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL reset_seq_active got=%b exp=0", seq_active); end
    apply_reset();
  endtask

  task automatic test_8086_selected();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b0; my_slave_id = 3'd3;
    cascading_lines = 3'd3; int_pending = 1'b1; vector_8086 = 8'h4B;
    clear_mon();
    inta_pulse(1);
    checks++; if (seq_active !== 1'b1) begin errors++; $display("FAIL sel86_seq_mid got=%b exp=1", seq_active); end
    inta_pulse(2);
    repeat (4) @(posedge clk); #1;
    checks++; if (isr_cnt !== 1) begin errors++; $display("FAIL sel86_isr_count got=%0d exp=1", isr_cnt); end
    checks++; if (isr_phase !== 2) begin errors++; $display("FAIL sel86_isr_phase got=%0d exp=2", isr_phase); end
    checks++; if (bytes.size() !== 1) begin errors++; $display("FAIL sel86_drive_count got=%0d exp=1", bytes.size()); end
    if (bytes.size() == 1) begin
      checks++; if (bytes[0] !== 8'h4B) begin errors++; $display("FAIL sel86_vector got=%h exp=4b", bytes[0]); end
      checks++; if (oe_phase[0] !== 3) begin errors++; $display("FAIL sel86_drive_phase got=%0d exp=3", oe_phase[0]); end
    end
    checks++; if (aeoi_cnt !== 0) begin errors++; $display("FAIL sel86_aeoi got=%0d exp=0", aeoi_cnt); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL sel86_seq_end got=%b exp=0", seq_active); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL sel86_oe_end got=%b exp=0", data_oe); end
  endtask

  task automatic test_8086_ignore();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b1; my_slave_id = 3'd3;
    cascading_lines = 3'd5; int_pending = 1'b1; vector_8086 = 8'h4B;
    clear_mon();
    inta_pulse(1);
    checks++; if (seq_active !== 1'b1) begin errors++; $display("FAIL ign_seq_mid got=%b exp=1", seq_active); end
    inta_pulse(2);
    repeat (4) @(posedge clk); #1;
    checks++; if (oe_cycles !== 0) begin errors++; $display("FAIL ign_oe_cycles got=%0d exp=0", oe_cycles); end
    checks++; if (isr_cnt !== 0) begin errors++; $display("FAIL ign_isr got=%0d exp=0", isr_cnt); end
    checks++; if (aeoi_cnt !== 0) begin errors++; $display("FAIL ign_aeoi got=%0d exp=0", aeoi_cnt); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL ign_seq_end got=%b exp=0", seq_active); end
  endtask

  task automatic test_8080_aeoi();
    mode_8086_flag = 1'b0; aeoi_flag = 1'b1; my_slave_id = 3'd1;
    cascading_lines = 3'd1; int_pending = 1'b1; call_addr = 16'hA520;
    clear_mon();
    inta_pulse(1);
    inta_pulse(2);
    checks++; if (seq_active !== 1'b1) begin errors++; $display("FAIL i80_seq_after2 got=%b exp=1", seq_active); end
    inta_pulse(3);
    repeat (4) @(posedge clk); #1;
    checks++; if (bytes.size() !== 2) begin errors++; $display("FAIL i80_drive_count got=%0d exp=2", bytes.size()); end
    if (bytes.size() == 2) begin
      checks++; if (bytes[0] !== 8'h20) begin errors++; $display("FAIL i80_low_byte got=%h exp=20", bytes[0]); end
      checks++; if (bytes[1] !== 8'hA5) begin errors++; $display("FAIL i80_high_byte got=%h exp=a5", bytes[1]); end
      checks++; if (oe_phase[0] !== 3) begin errors++; $display("FAIL i80_low_phase got=%0d exp=3", oe_phase[0]); end
      checks++; if (oe_phase[1] !== 5) begin errors++; $display("FAIL i80_high_phase got=%0d exp=5", oe_phase[1]); end
    end
    checks++; if (isr_cnt !== 1) begin errors++; $display("FAIL i80_isr got=%0d exp=1", isr_cnt); end
    checks++; if (aeoi_cnt !== 1) begin errors++; $display("FAIL i80_aeoi got=%0d exp=1", aeoi_cnt); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL i80_seq_end got=%b exp=0", seq_active); end
  endtask

  task automatic test_vector_freeze();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b0; my_slave_id = 3'd3;
    cascading_lines = 3'd3; int_pending = 1'b1; vector_8086 = 8'h4B;
    clear_mon();
    inta_pulse(1);
    vector_8086 = 8'h4C; cascading_lines = 3'd6; int_pending = 1'b0;
    inta_pulse(2);
    repeat (4) @(posedge clk); #1;
    checks++; if (bytes.size() !== 1) begin errors++; $display("FAIL frz_drive_count got=%0d exp=1", bytes.size()); end
    if (bytes.size() == 1) begin
      checks++; if (bytes[0] !== 8'h4B) begin errors++; $display("FAIL frz_vector got=%h exp=4b", bytes[0]); end
    end
  endtask

  task automatic test_reset_mid_drive();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b0; my_slave_id = 3'd3;
    cascading_lines = 3'd3; int_pending = 1'b1; vector_8086 = 8'h4B;
    clear_mon();
    inta_pulse(1);
    @(posedge clk); #1;
    inta_neg = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL rstmid_oe_before got=%b exp=1", data_oe); end
    #2 rst_neg = 1'b0;
    #1;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe_async got=%b exp=0", data_oe); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL rstmid_seq got=%b exp=0", seq_active); end
    inta_neg = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_neg = 1'b1;
    repeat (4) @(posedge clk);
    clear_mon();
    inta_pulse(1);
    inta_pulse(2);
    repeat (4) @(posedge clk); #1;
    checks++; if (bytes.size() !== 1) begin errors++; $display("FAIL rstmid_new_count got=%0d exp=1", bytes.size()); end
    if (bytes.size() == 1) begin
      checks++; if (bytes[0] !== 8'h4B) begin errors++; $display("FAIL rstmid_new_vector got=%h exp=4b", bytes[0]); end
    end
    checks++; if (isr_cnt !== 1) begin errors++; $display("FAIL rstmid_new_isr got=%0d exp=1", isr_cnt); end
  endtask

  task automatic test_inert();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b1; my_slave_id = 3'd3;
    cascading_lines = 3'd3; int_pending = 1'b1; vector_8086 = 8'h4B;
    for (int k = 0; k < 2; k++) begin
      sp_neg = (k == 0); single_mode_flag = (k == 1);
      clear_mon();
      inta_pulse(1);
      inta_pulse(2);
      repeat (4) @(posedge clk); #1;
      checks++; if (seq_cycles !== 0) begin errors++; $display("FAIL inert%0d_seq got=%0d exp=0", k, seq_cycles); end
      checks++; if (oe_cycles !== 0) begin errors++; $display("FAIL inert%0d_oe got=%0d exp=0", k, oe_cycles); end
      checks++; if (isr_cnt + aeoi_cnt !== 0) begin errors++; $display("FAIL inert%0d_pulses got=%0d exp=0", k, isr_cnt + aeoi_cnt); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL inert%0d_data got=%h exp=00", k, data_out); end
    end
    sp_neg = 1'b0; single_mode_flag = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_abort();
    mode_8086_flag = 1'b1; aeoi_flag = 1'b1; my_slave_id = 3'd3;
    cascading_lines = 3'd3; int_pending = 1'b1; vector_8086 = 8'h4B;
    clear_mon();
    inta_pulse(1);
    @(posedge clk); #1;
    inta_neg = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_before got=%b exp=1", data_oe); end
    sp_neg = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got=%b exp=0", data_oe); end
    checks++; if (seq_active !== 1'b0) begin errors++; $display("FAIL abort_seq got=%b exp=0", seq_active); end
    inta_neg = 1'b1;
    repeat (8) @(posedge clk); #1;
    checks++; if (aeoi_cnt !== 0) begin errors++; $display("FAIL abort_aeoi got=%0d exp=0", aeoi_cnt); end
    sp_neg = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    isr_cnt = 0; aeoi_cnt = 0; oe_cycles = 0; seq_cycles = 0;
    isr_phase = 0; oe_prev = 1'b0;
    apply_reset();
    test_reset();
    test_8086_selected();
    test_8086_ignore();
    test_8080_aeoi();
    test_vector_freeze();
    test_reset_mid_drive();
    test_inert();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
